// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Producer of the instruction stream for decode. Holds the fetch PC, issues
//   word reads to instruction memory, buffers returned words in order and hands
//   {instr, instr_pc} to decode over a valid/ready handshake. Redirects from
//   execute flush the buffer and drop any wrong-path words still in flight.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   mem_req_valid/addr/ready        read request channel (word aligned)
//   mem_rsp_valid/data              in-order read return, always accepted
//   instr_valid/instr/instr_pc      buffer head to decode
//   instr_ready                     decode consumes head
//   redirect_valid/redirect_pc      control-flow change (one-cycle pulse)
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// FETCH | issuing requests while credits allow
// DRAIN | waiting for wrong-path responses to return and be dropped
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(BUF_DEPTH);

   typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [31:0]      buf_instr_q [BUF_DEPTH];
   logic [31:0]      buf_pc_q    [BUF_DEPTH];

   logic             pop_fire, req_fire, rsp_take, push;
   logic             credit_ok;
   logic [CNT_W:0]   inflight;
   logic [31:0]      rsp_pc;
   logic             unused_ok;

   assign pop_fire = (count_q != '0) && instr_ready;
   assign req_fire = mem_req_valid && mem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_take = mem_rsp_valid && ((outst_q != '0) || (discard_q != '0));
   assign push     = rsp_take && (discard_q == '0) && !redirect_valid;

   // A slot freed by this cycle's pop may be reused immediately; this keeps
   // one instruction per cycle with a 1-cycle memory and two entries.
   assign credit_ok = (({1'b0, outst_q} + {1'b0, count_q}) <
                       (DEPTH_C + (CNT_W+1)'(pop_fire)));

   // Non-dropped in-flight requests are always consecutive words ending just
   // below fetch_pc, so the oldest one's address follows from the count.
   assign rsp_pc = fetch_pc_q - {{(30-CNT_W){1'b0}}, outst_q, 2'b00};

   assign inflight = {1'b0, discard_q} + {1'b0, outst_q}
                   + (CNT_W+1)'(req_fire) - (CNT_W+1)'(rsp_take);

   assign unused_ok = ^{redirect_pc[1:0], inflight[CNT_W]};

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_BOOT;
      else        state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:  state_d = ST_FETCH;
         ST_FETCH: if (redirect_valid && (discard_d != '0)) state_d = ST_DRAIN;
         ST_DRAIN: if (discard_d == '0) state_d = ST_FETCH;
         default:  state_d = ST_BOOT;
      endcase
   end

   // outputs
   always_comb begin
      mem_req_valid = (state_q == ST_FETCH) && credit_ok;
      mem_req_addr  = fetch_pc_q;
      instr_valid   = (count_q != '0);
      instr         = buf_instr_q[head_q];
      instr_pc      = buf_pc_q[head_q];
   end

   // datapath next state
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (redirect_valid) begin
         // everything still in flight, including a request firing now,
         // becomes wrong-path and is dropped on return
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         outst_d    = '0;
         discard_d  = inflight[CNT_W-1:0];
         count_d    = '0;
         head_d     = tail_q;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_take && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
         outst_d = outst_q + CNT_W'(req_fire)
                 - CNT_W'(rsp_take && (discard_q == '0));
         if (push)     tail_d = tail_q + PTR_W'(1);
         if (pop_fire) head_d = head_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop_fire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_instr_q[i] <= '0;
            buf_pc_q[i]    <= '0;
         end
      end else if (push) begin
         buf_instr_q[tail_q] <= mem_rsp_data;
         buf_pc_q[tail_q]    <= rsp_pc;
      end
   end

   rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
      mem_rsp_valid |-> ((outst_q != '0) || (discard_q != '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          fires = 0;
   bit          mem_en = 1'b1;
   bit          want_ready = 1'b0;
   bit          rd_req = 1'b0;
   logic [31:0] rd_pc = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   task automatic push_exp(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   // one cycle: drive inputs at negedge, model a 1-cycle in-order memory
   task automatic step();
      @(negedge clk);
      cyc++;
      if (mem_en && mq.size() > 0 && mq[0].cyc < cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = mem_word(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
      redirect_valid = rd_req;
      redirect_pc    = rd_pc;
      rd_req         = 1'b0;
      instr_ready    = want_ready && (exp_q.size() > 0);
      #1;
      if (mem_req_valid && mem_req_ready) begin
         mq.push_back('{addr: mem_req_addr, cyc: cyc});
         fires++;
      end
   endtask

   task automatic drive_idle_assert_reset();
      rst_n          = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      rd_req         = 1'b0;
      mq.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
      check({tag, "_req_addr"}, mem_req_addr, 32'h0);
      check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_instr"}, instr, 32'h0);
      check({tag, "_instr_pc"}, instr_pc, 32'h0);
   endtask

   task automatic do_reset();
      drive_idle_assert_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      cyc   = 0;
      fires = 0;
      #1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // scoreboard monitor
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_instr: got pc 0x%08h with nothing expected", instr_pc);
            end else begin
               e = exp_q.pop_front();
               check("instr_pc", instr_pc, e);
               check("instr", instr, mem_word(e));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      mem_req_ready = 1'b1;
      drive_idle_assert_reset();

      // boot timing and back-to-back streaming
      do_reset();
      check("boot_no_req", 32'(mem_req_valid), 32'd0);
      mem_en = 1'b1;
      want_ready = 1'b1;
      push_exp(32'h0, 16);
      step();
      check("cyc1_req_valid", 32'(mem_req_valid), 32'd1);
      check("cyc1_req_addr", mem_req_addr, 32'h0);
      step();
      check("cyc2_req_addr", mem_req_addr, 32'h4);
      n = 0;
      while (!instr_valid && n < 20) begin step(); n++; end
      check("first_valid_seen", 32'(instr_valid), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check("no_bubble", 32'(instr_valid), 32'd1);
         step();
      end
      wait_drain("stream_drained");

      // backpressure: two words buffered, then fetch stops
      do_reset();
      want_ready = 1'b0;
      push_exp(32'h0, 8);
      repeat (8) step();
      check("bp_fires", 32'(fires), 32'd2);
      check("bp_req_valid", 32'(mem_req_valid), 32'd0);
      check("bp_instr_valid", 32'(instr_valid), 32'd1);
      check("bp_head_pc", instr_pc, 32'h0);
      want_ready = 1'b1;
      wait_drain("bp_drained");

      // redirect with two requests outstanding
      do_reset();
      mem_en = 1'b0;
      want_ready = 1'b1;
      repeat (5) step();
      check("rd_fires", 32'(fires), 32'd2);
      check("rd_req_blocked", 32'(mem_req_valid), 32'd0);
      rd_req = 1'b1;
      rd_pc  = 32'h0000_0103;
      step();
      step();
      check("rd_new_addr", mem_req_addr, 32'h0000_0100);
      check("rd_drain_no_req", 32'(mem_req_valid), 32'd0);
      push_exp(32'h0000_0100, 4);
      mem_en = 1'b1;
      wait_drain("rd_drained");

      // redirect near the top of the address space: pc wraps to zero
      repeat (6) step();
      rd_req = 1'b1;
      rd_pc  = 32'hFFFF_FFF9;
      step();
      push_exp(32'hFFFF_FFF8, 4);
      wait_drain("wrap_drained");

      // redirect in the same cycle as a request fire and a response
      do_reset();
      mem_en = 1'b1;
      want_ready = 1'b1;
      step();
      rd_req = 1'b1;
      rd_pc  = 32'h0000_0200;
      step();
      check("coincide_req", 32'(mem_req_valid && mem_req_ready), 32'd1);
      check("coincide_rsp", 32'(mem_rsp_valid), 32'd1);
      push_exp(32'h0000_0200, 4);
      step();
      check("post_rd_invalid", 32'(instr_valid), 32'd0);
      wait_drain("coincide_drained");

      // reset in the middle of the stream
      do_reset();
      mem_en = 1'b1;
      want_ready = 1'b1;
      push_exp(32'h0, 16);
      n = 0;
      while (mem_req_addr != 32'h40 && n < 100) begin step(); n++; end
      check("mid_reached_0x40", mem_req_addr, 32'h40);
      drive_idle_assert_reset();
      #1;
      check_reset_outputs("mid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      fires = 0;
      #1;
      push_exp(32'h0, 4);
      step();
      check("restart_addr", mem_req_addr, 32'h0);
      wait_drain("restart_drained");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
